// File: rtl/npc_ctrl_pkg.sv
// Shared encodings for the NPC multi-cycle sequencer: states, instruction
// classes, opcode constants and PC-select codes.
package npc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_FETCH  = 4'd1,
        S_WAIT_I = 4'd2,
        S_DECODE = 4'd3,
        S_EXEC   = 4'd4,
        S_MEM    = 4'd5,
        S_WAIT_M = 4'd6,
        S_WB     = 4'd7,
        S_HALT   = 4'd8,
        S_ERR    = 4'd9
    } state_e;

    typedef enum logic [3:0] {
        CLS_LOAD    = 4'd0,
        CLS_STORE   = 4'd1,
        CLS_OPIMM   = 4'd2,
        CLS_OP      = 4'd3,
        CLS_LUI     = 4'd4,
        CLS_AUIPC   = 4'd5,
        CLS_JAL     = 4'd6,
        CLS_JALR    = 4'd7,
        CLS_BRANCH  = 4'd8,
        CLS_SYSTEM  = 4'd9,
        CLS_UNKNOWN = 4'd10
    } cls_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_NOP    = 32'h0000_0013;

    localparam logic [1:0] PC_SEL_SEQ = 2'd0;
    localparam logic [1:0] PC_SEL_BR  = 2'd1;
    localparam logic [1:0] PC_SEL_JMP = 2'd2;

    function automatic logic cls_is_mem(input cls_e c);
        return (c == CLS_LOAD) || (c == CLS_STORE);
    endfunction

endpackage

// File: rtl/npc_inst_classify.sv
// Combinational opcode classifier: instruction class, rd-write, ebreak and
// illegal-encoding flags for the sequencer's decode stage.
module npc_inst_classify
    import npc_ctrl_pkg::*;
(
    input  logic [31:0] inst,
    output cls_e        cls,
    output logic        writes_rd,
    output logic        is_ebreak,
    output logic        is_illegal
);

    always_comb begin
        cls = CLS_UNKNOWN;
        unique case (inst[6:0])
            OPC_LOAD:   cls = CLS_LOAD;
            OPC_STORE:  cls = CLS_STORE;
            OPC_OPIMM:  cls = CLS_OPIMM;
            OPC_OP:     cls = CLS_OP;
            OPC_LUI:    cls = CLS_LUI;
            OPC_AUIPC:  cls = CLS_AUIPC;
            OPC_JAL:    cls = CLS_JAL;
            OPC_JALR:   cls = CLS_JALR;
            OPC_BRANCH: cls = CLS_BRANCH;
            OPC_SYSTEM: cls = CLS_SYSTEM;
            default:    cls = CLS_UNKNOWN;
        endcase

        is_ebreak  = (inst == INST_EBREAK);
        is_illegal = (cls == CLS_UNKNOWN) || ((cls == CLS_SYSTEM) && !is_ebreak);
        // True only when a real (non-x0) destination register gets written.
        writes_rd  = (inst[11:7] != 5'd0) &&
                     !(cls inside {CLS_STORE, CLS_BRANCH, CLS_SYSTEM, CLS_UNKNOWN});
    end

endmodule

// File: rtl/npc_ctrl.sv
// NPC multi-cycle sequencer: fetch handshake, decode, execute, memory and
// write-back control. Optional counters enabled by NPC_CTRL_PERF_EN.
module npc_ctrl
    import npc_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 256,
    parameter int unsigned TO_W    = 8
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ifu_req_valid,
    input  logic        ifu_req_ready,
    input  logic        ifu_rsp_valid,
    input  logic [31:0] ifu_rsp_inst,
    output logic [31:0] inst,
    output logic        lsu_req_valid,
    input  logic        lsu_req_ready,
    output logic        lsu_req_wen,
    input  logic        lsu_rsp_valid,
    input  logic        br_taken,
    output logic        rf_wen,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        halt,
    output logic        illegal,
    output logic [63:0] perf_cycle,
    output logic [63:0] perf_instret
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_e          state_q, state_nx;
    logic [31:0]     inst_q, inst_nx;
    logic [TO_W-1:0] wd_q, wd_nx, wd_inc;
    logic            wd_expired;

    cls_e cls;
    logic writes_rd, is_ebreak, is_illegal;

    npc_inst_classify u_classify (
        .inst       (inst_q),
        .cls        (cls),
        .writes_rd  (writes_rd),
        .is_ebreak  (is_ebreak),
        .is_illegal (is_illegal)
    );

    assign inst       = inst_q;
    assign wd_expired = (wd_q == TO_LAST);
    assign wd_inc     = (wd_q == '1) ? wd_q : wd_q + TO_W'(1);

    // State, instruction and watchdog registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RESET;
            inst_q  <= INST_NOP;
            wd_q    <= '0;
        end else begin
            state_q <= state_nx;
            inst_q  <= inst_nx;
            wd_q    <= wd_nx;
        end
    end

    // Next-state and Moore output decode.
    always_comb begin
        state_nx      = state_q;
        inst_nx       = inst_q;
        wd_nx         = '0;
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        lsu_req_wen   = 1'b0;
        rf_wen        = 1'b0;
        pc_we         = 1'b0;
        pc_sel        = PC_SEL_SEQ;
        halt          = 1'b0;
        illegal       = 1'b0;

        unique case (state_q)
            S_RESET: state_nx = S_FETCH;
            S_FETCH: begin
                ifu_req_valid = 1'b1;
                if (ifu_req_ready) state_nx = S_WAIT_I;
            end
            S_WAIT_I: begin
                if (ifu_rsp_valid) begin
                    inst_nx  = ifu_rsp_inst;
                    state_nx = S_DECODE;
                end else if (wd_expired) begin
                    state_nx = S_ERR;
                end else begin
                    wd_nx = wd_inc;
                end
            end
            S_DECODE: begin
                if (is_ebreak)       state_nx = S_HALT;
                else if (is_illegal) state_nx = S_ERR;
                else                 state_nx = S_EXEC;
            end
            S_EXEC: state_nx = cls_is_mem(cls) ? S_MEM : S_WB;
            S_MEM: begin
                lsu_req_valid = 1'b1;
                lsu_req_wen   = (cls == CLS_STORE);
                if (lsu_req_ready) state_nx = S_WAIT_M;
            end
            S_WAIT_M: begin
                if (lsu_rsp_valid) begin
                    state_nx = S_WB;
                end else if (wd_expired) begin
                    state_nx = S_ERR;
                end else begin
                    wd_nx = wd_inc;
                end
            end
            S_WB: begin
                pc_we    = 1'b1;
                rf_wen   = writes_rd;
                state_nx = S_FETCH;
                if ((cls == CLS_JAL) || (cls == CLS_JALR)) pc_sel = PC_SEL_JMP;
                else if ((cls == CLS_BRANCH) && br_taken)  pc_sel = PC_SEL_BR;
            end
            S_HALT: halt = 1'b1;
            S_ERR:  illegal = 1'b1;
            default: state_nx = S_ERR;
        endcase
    end

`ifdef NPC_CTRL_PERF_EN
    logic [63:0] cyc_q, ret_q;
    logic        retire;

    // A WB cycle retires its instruction; ebreak retires on entry to HALT.
    assign retire = (state_q == S_WB) || ((state_q != S_HALT) && (state_nx == S_HALT));

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            cyc_q <= cyc_q + 64'd1;
            if (retire) ret_q <= ret_q + 64'd1;
        end
    end

    assign perf_cycle   = cyc_q;
    assign perf_instret = ret_q;
`else
    assign perf_cycle   = '0;
    assign perf_instret = '0;
`endif

endmodule

// File: tb/tb_npc_ctrl.sv
// Self-checking bench for npc_ctrl: scripted memory agents with random delays
// and noise, and a timeline model of the expected per-cycle outputs.
module tb_npc_ctrl;

    localparam int TIMEOUT = 256;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    // exp_ctrl bit layout: {ifu_req_valid, lsu_req_valid, lsu_req_wen, rf_wen, pc_we, pc_sel[1:0], halt, illegal}
    localparam int B_IFU = 8, B_LSU = 7, B_WEN = 6, B_RF = 5, B_PCWE = 4, B_HALT = 1, B_ILL = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ifu_req_valid, ifu_req_ready = 1'b0, ifu_rsp_valid = 1'b0;
    logic [31:0] ifu_rsp_inst = '0, inst;
    logic        lsu_req_valid, lsu_req_ready = 1'b0, lsu_req_wen, lsu_rsp_valid = 1'b0;
    logic        br_taken = 1'b0, rf_wen, pc_we, halt, illegal;
    logic [1:0]  pc_sel;
    logic [63:0] perf_cycle, perf_instret;

    npc_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_inst  (ifu_rsp_inst),
        .inst          (inst),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_req_wen   (lsu_req_wen),
        .lsu_rsp_valid (lsu_rsp_valid),
        .br_taken      (br_taken),
        .rf_wen        (rf_wen),
        .pc_we         (pc_we),
        .pc_sel        (pc_sel),
        .halt          (halt),
        .illegal       (illegal),
        .perf_cycle    (perf_cycle),
        .perf_instret  (perf_instret)
    );

    always #5 clk = ~clk;

    int unsigned n_total = 0, n_pass = 0;
    logic [8:0]  exp_ctrl = '0;
    logic [31:0] exp_inst = NOP, cur_inst = NOP;
    logic [63:0] m_cyc = '0, m_ret = '0;
    logic        pend_ret = 1'b0;
    bit          chk_en = 1'b0;
    int          mode = 0;   // 0 running, 1 halted, 2 error

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, got, want, $time);
    endtask

    // Compare process: DUT outputs against the timeline model every cycle.
    always @(negedge clk) begin
        logic [127:0] exp_perf;
        if (chk_en) begin
`ifdef NPC_CTRL_PERF_EN
            exp_perf = {m_cyc, m_ret};
`else
            exp_perf = '0;
`endif
            check("ctrl", 128'({ifu_req_valid, lsu_req_valid, lsu_req_wen, rf_wen, pc_we,
                                pc_sel, halt, illegal}), 128'(exp_ctrl));
            check("inst", 128'(inst), 128'(exp_inst));
            check("perf", {perf_cycle, perf_instret}, exp_perf);
        end
    end

    // Observed FETCH-to-WB latency and WB outputs, for literal expectations.
    int   lat = 0, last_lat = 0;
    logic prev_ifu = 1'b0, last_rf = 1'b0;
    logic [1:0] last_sel = '0;
    always @(negedge clk) begin
        if (ifu_req_valid && !prev_ifu) lat = 1;
        else lat++;
        if (pc_we) begin
            last_lat = lat;
            last_rf  = rf_wen;
            last_sel = pc_sel;
        end
        prev_ifu = ifu_req_valid;
    end

    function automatic int kind(input logic [31:0] i);
        case (i[6:0])
            7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0110111,
            7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011: return 0;
            default: return (i == EBREAK) ? 1 : 2;
        endcase
    endfunction

    function automatic logic writes_rd(input logic [31:0] i);
        return (i[6:0] != 7'b0100011) && (i[6:0] != 7'b1100011) && (i[11:7] != 5'd0);
    endfunction

    function automatic logic [1:0] exp_sel(input logic [31:0] i, input logic br);
        if (i[6:0] == 7'b1101111 || i[6:0] == 7'b1100111) return 2'd2;
        if (i[6:0] == 7'b1100011 && br) return 2'd1;
        return 2'd0;
    endfunction

    // Advance one cycle: update perf model, randomise all inputs as noise.
    task automatic begin_cycle();
        @(posedge clk);
        #1;
        if (rst) begin
            m_cyc = '0;
            m_ret = '0;
        end else begin
            m_cyc++;
            if (pend_ret) m_ret++;
        end
        pend_ret      = 1'b0;
        ifu_req_ready = 1'($urandom_range(0, 1));
        ifu_rsp_valid = 1'($urandom_range(0, 1));
        ifu_rsp_inst  = $urandom;
        lsu_req_ready = 1'($urandom_range(0, 1));
        lsu_rsp_valid = 1'($urandom_range(0, 1));
        br_taken      = 1'($urandom_range(0, 1));
        chk_en        = 1'b1;
        exp_inst      = cur_inst;
        exp_ctrl      = '0;
        if (mode == 1) exp_ctrl[B_HALT] = 1'b1;
        if (mode == 2) exp_ctrl[B_ILL]  = 1'b1;
    endtask

    task automatic do_reset(input bit stale);
        begin_cycle();
        rst      = 1'b1;
        chk_en   = 1'b0;
        mode     = 0;
        cur_inst = NOP;
        begin_cycle();
        rst = 1'b0;
        if (stale) begin
            ifu_rsp_valid = 1'b1;
            lsu_rsp_valid = 1'b1;
        end
    endtask

    task automatic idle(input int k);
        for (int j = 0; j < k; j++) begin_cycle();
    endtask

    // One instruction: a/b = IFU ready/response delay, m/n = LSU delays, br 0/1 or 2=random.
    task automatic run_inst(input logic [31:0] instr, input int a, input int b,
                            input int m, input int n, input int br);
        logic st;
        for (int j = 0; j <= a; j++) begin
            begin_cycle();
            ifu_req_ready = (j == a);
            exp_ctrl[B_IFU] = 1'b1;
        end
        for (int j = 0; j < TIMEOUT; j++) begin
            begin_cycle();
            ifu_rsp_valid = (j == b);
            if (j == b) begin
                ifu_rsp_inst = instr;
                break;
            end
        end
        if (b >= TIMEOUT) begin
            mode = 2;
            return;
        end
        begin_cycle();
        cur_inst = instr;
        exp_inst = instr;
        if (kind(instr) == 1) begin
            pend_ret = 1'b1;
            mode = 1;
            return;
        end
        if (kind(instr) == 2) begin
            mode = 2;
            return;
        end
        begin_cycle();
        if (instr[6:0] == 7'b0000011 || instr[6:0] == 7'b0100011) begin
            st = (instr[6:0] == 7'b0100011);
            for (int j = 0; j <= m; j++) begin
                begin_cycle();
                lsu_req_ready = (j == m);
                exp_ctrl[B_LSU] = 1'b1;
                exp_ctrl[B_WEN] = st;
            end
            for (int j = 0; j < TIMEOUT; j++) begin
                begin_cycle();
                lsu_rsp_valid = (j == n);
                if (j == n) break;
            end
            if (n >= TIMEOUT) begin
                mode = 2;
                return;
            end
        end
        begin_cycle();
        if (br != 2) br_taken = (br == 1);
        exp_ctrl[B_PCWE] = 1'b1;
        exp_ctrl[B_RF]   = writes_rd(instr);
        exp_ctrl[3:2]    = exp_sel(instr, br_taken);
        pend_ret = 1'b1;
    endtask

    task automatic sync_neg();
        @(negedge clk);
        #1;
    endtask

    function automatic int pick_delay();
        if ($urandom_range(0, 9) == 0) return int'($urandom_range(4, 12));
        return int'($urandom_range(0, 2));
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0]  ops [9] = '{7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0110111,
                                 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011};
        logic [31:0] x = $urandom;
        int unsigned r = $urandom_range(0, 19);
        if (r == 0) return EBREAK;
        if (r == 1) return x;
        if (r == 2) return {x[31:7], 7'b1110011};
        return {x[31:7], ops[$urandom_range(0, 8)]};
    endfunction

    initial begin
        logic [63:0] lit_ret, lit_cyc;
        do_reset(1'b0);

        run_inst(32'h0050_0093, 0, 0, 0, 0, 2);   // addi x1,x0,5
        sync_neg();
        check("lat_addi", 128'(last_lat), 128'(5));
        check("rf_addi", 128'(last_rf), 128'(1));
        check("sel_addi", 128'(last_sel), 128'(0));

        run_inst(32'h0020_a023, 0, 0, 0, 0, 2);   // sw
        sync_neg();
        check("lat_sw", 128'(last_lat), 128'(7));
        check("rf_sw", 128'(last_rf), 128'(0));
        run_inst(32'h0000_a183, 0, 0, 0, 0, 2);   // lw
        sync_neg();
        check("lat_lw", 128'(last_lat), 128'(7));
        check("rf_lw", 128'(last_rf), 128'(1));

        run_inst(32'h0000_0463, 0, 0, 0, 0, 1);   // beq taken
        sync_neg();
        check("sel_beq", 128'(last_sel), 128'(1));
        check("rf_beq", 128'(last_rf), 128'(0));
        run_inst(32'h0000_006f, 0, 0, 0, 0, 2);   // jal x0
        sync_neg();
        check("sel_jal", 128'(last_sel), 128'(2));
        check("rf_jal", 128'(last_rf), 128'(0));

        run_inst(32'h0050_0093, 10, 0, 0, 0, 2);  // IFU backpressure
        run_inst(32'h0000_a183, 0, 0, 0, 255, 2); // response on the last legal cycle
        sync_neg();
        check("lat_slow_lw", 128'(last_lat), 128'(262));

        run_inst(32'h0000_a183, 0, 0, 0, 256, 2); // LSU watchdog
        idle(4);
        sync_neg();
        check("lit_timeout", 128'(illegal), 128'(1));
        do_reset(1'b1);
        run_inst(32'h0050_0093, 0, 256, 0, 0, 2); // IFU watchdog
        idle(3);
        do_reset(1'b1);

        run_inst(32'h0000_007f, 0, 0, 0, 0, 2);   // unknown opcode
        idle(4);
        sync_neg();
        check("lit_illegal", 128'(illegal), 128'(1));
        do_reset(1'b1);
        sync_neg();
        check("lit_flags_clear", 128'({halt, illegal}), 128'(0));

        for (int k = 0; k < 3; k++) run_inst(32'h0050_0093, 0, 0, 0, 0, 2);
        run_inst(EBREAK, 0, 0, 0, 0, 2);
        idle(5);
        sync_neg();
        check("lit_halt", 128'(halt), 128'(1));
`ifdef NPC_CTRL_PERF_EN
        lit_ret = 64'd4;
        lit_cyc = 64'd23;
`else
        lit_ret = 64'd0;
        lit_cyc = 64'd0;
`endif
        check("lit_instret", 128'(perf_instret), 128'(lit_ret));
        check("lit_cycle", 128'(perf_cycle), 128'(lit_cyc));
        do_reset(1'b1);

        // Mid-transaction abort followed by a stale response.
        begin_cycle();
        ifu_req_ready = 1'b1;
        exp_ctrl[B_IFU] = 1'b1;
        begin_cycle();
        ifu_rsp_valid = 1'b0;
        do_reset(1'b1);

        for (int t = 0; t < 250; t++) begin
            run_inst(rand_inst(), pick_delay(), pick_delay(), pick_delay(), pick_delay(), 2);
            if (mode != 0) begin
                idle(int'($urandom_range(1, 4)));
                do_reset(1'($urandom_range(0, 1)));
            end
        end

        sync_neg();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/npc_ctrl.md
Name: npc_ctrl

Overview:
- Multi-cycle sequencer for the NPC core datapath.
- Drives the instruction-fetch handshake and latches the fetched instruction for the decoder.
- Classifies the opcode, sequences execute, memory and write-back, and issues the register-file write enable and PC update.
- Sits between the IFU/LSU memory ports and the decoder/RegisterFile/PC logic.

Parameters:
- TIMEOUT, 256, cycle limit for any single wait on ifu_rsp_valid or lsu_rsp_valid before entering ERR.
- TO_W, 8, width of the watchdog counter; must satisfy 2^TO_W >= TIMEOUT.

Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- ifu_req_valid  out  1  fetch request
- ifu_req_ready  in  1  IFU accepts request
- ifu_rsp_valid  in  1  fetched instruction valid
- ifu_rsp_inst  in  32  fetched instruction
- inst  out  32  latched instruction for decoder
- lsu_req_valid  out  1  load/store request
- lsu_req_ready  in  1  LSU accepts request
- lsu_req_wen  out  1  1=store, 0=load
- lsu_rsp_valid  in  1  load data ready / store done
- br_taken  in  1  branch condition from datapath, sampled in WB
- rf_wen  out  1  RegisterFile write enable pulse
- pc_we  out  1  PC update pulse
- pc_sel  out  2  0=pc+4, 1=branch target, 2=jump target
- halt  out  1  ebreak retired (sticky)
- illegal  out  1  illegal opcode or watchdog timeout (sticky)
- perf_cycle  out  64  cycle count (optional feature)
- perf_instret  out  64  retired instruction count (optional feature)

Behaviour:
- States: RESET, FETCH, WAIT_I, DECODE, EXEC, MEM, WAIT_M, WB, HALT, ERR.
- Outputs are Moore, decoded from the state and the inst register.
- Reset state: RESET, inst=0x00000013, watchdog counter=0. All outputs are 0 in RESET, HALT and ERR, except the sticky flags.
- RESET -> FETCH unconditionally on the first cycle with rst low.
- FETCH:
  - ifu_req_valid=1, held until ifu_req_ready=1; valid is never withdrawn.
  - On ready -> WAIT_I.
- WAIT_I:
  - Watchdog counter increments each cycle.
  - On ifu_rsp_valid: latch ifu_rsp_inst into inst, clear the counter -> DECODE.
  - If the counter reaches TIMEOUT-1 with no response -> ERR.
- DECODE: classify inst[6:0] into LOAD 0000011, STORE 0100011, OPIMM 0010011, OP 0110011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, or SYSTEM.
  - inst==0x00100073 (ebreak) -> HALT.
  - Any other SYSTEM encoding or an unknown opcode -> ERR.
  - All other classes -> EXEC.
- EXEC: one cycle. LOAD/STORE -> MEM; all other classes -> WB.
- MEM:
  - lsu_req_valid=1 and lsu_req_wen=(class==STORE), both held until lsu_req_ready=1.
  - On ready -> WAIT_M.
- WAIT_M:
  - Same watchdog as WAIT_I.
  - On lsu_rsp_valid -> WB.
- WB: exactly one cycle, then -> FETCH.
  - pc_we=1.
  - pc_sel=2 for JAL/JALR.
  - pc_sel=1 for BRANCH with br_taken=1.
  - pc_sel=0 otherwise.
  - rf_wen=1 iff the class writes rd (not STORE, not BRANCH) and inst[11:7]!=0.
- Latency, zero-wait memory (ready same cycle, response next cycle):
  - ALU instruction: 5 cycles FETCH to WB.
  - Load/store: 7 cycles.
- Sticky flags:
  - HALT sets halt=1; ERR sets illegal=1.
  - Both are terminal; only rst exits them.
- Responses arriving in any state other than the matching WAIT state are ignored.
- rst asserted mid-transaction aborts it; a stale response after reset is ignored because the state is RESET/FETCH.
- Watchdog counter saturates and never wraps.

Optional Feature:
- NPC_CTRL_PERF_EN:
  - Defined: perf_cycle increments every cycle with rst low; perf_instret increments on every WB cycle and on entry to HALT. Both are 64-bit, wrap modulo 2^64, and clear on rst.
  - Undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Package npc_ctrl_pkg holds:
  - the state encoding;
  - the instruction-class encoding;
  - the opcode constants;
  - the EBREAK and NOP constants;
  - the pc_sel encodings.
- One combinational sub-module, npc_inst_classify (inst in -> class, writes_rd, is_ebreak, is_illegal), reused by the decoder.

Test Plan:
- ALU op: addi x1,x0,5 (0x00500093), zero-wait memory -> rf_wen=1 and pc_we=1 in cycle 5 after FETCH, pc_sel=0.
- Store then load: sw (0x0020a023) then lw (0x0000a183) -> lsu_req_wen=1 then 0; rf_wen=0 for sw, 1 for lw; 7 cycles each.
- Branch: beq (0x00000463) with br_taken=1 -> pc_sel=1, rf_wen=0. JAL x0 (0x0000006f) -> pc_sel=2, rf_wen=0 because rd=0.
- Backpressure: hold ifu_req_ready=0 for 10 cycles -> ifu_req_valid stays 1 throughout; withhold lsu_rsp_valid for 256 cycles -> illegal=1, state ERR.
- Terminal cases:
  - ebreak (0x00100073) -> halt=1, no further ifu_req_valid.
  - Opcode 0x0000007f -> illegal=1.
  - rst pulse -> both flags clear and fetch restarts.
- Perf (NPC_CTRL_PERF_EN defined): 3 addi instructions then ebreak -> perf_instret=4; perf_cycle equals the elapsed cycles since rst fell.
